// File: rtl/led_frame_pkg.sv
// led_frame_pkg: shared types and widths for the LED frame reader
package led_frame_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam int PIX_W = 24;
  localparam int MEM_DATA_W = 32;
  localparam int RD_LAT = 1;
endpackage

// File: rtl/led_pix_fifo.sv
// led_pix_fifo: register-array sync FIFO; ports push/din, pop/dout, flush, count, empty, full
module led_pix_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/led_frame_reader.sv
// led_frame_reader: Avalon-MM read master streaming a frame of GRB pixels to the LED encoder
// ports: start/abort/base_addr/num_words -> busy/done; mem_* read port; pix_* stream out
module led_frame_reader
  import led_frame_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  input  logic [MEM_DATA_W-1:0] mem_readdata,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, addr_q, addr_d, src_addr;
  logic [15:0] req_left_q, req_left_d, out_left_q, out_left_d, src_left;
  logic cs_q, cs_d, inflight_q, inflight_d, done_q, done_d, zero_q, zero_d;
  logic accept, issue, push, pop, credit_ok, fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  // credit counts words already buffered, returning this cycle, and requested this cycle,
  // so the decision never depends on pix_ready
  always_comb begin
    push = inflight_q && !abort;
    pop = pix_valid && pix_ready;
    accept = state_q == IDLE && start && !abort;
    src_addr = state_q == IDLE ? base_addr : rd_addr_q;
    src_left = state_q == IDLE ? num_words : req_left_q;
    credit_ok = !fifo_full &&
      (32'(fifo_count) + 32'(inflight_q) + 32'(cs_q) < 32'(FIFO_DEPTH));
    issue = !abort && ((accept && num_words != 16'd0) ||
      (state_q == FETCH && req_left_q != 16'd0 && credit_ok));
    state_d = state_q;
    rd_addr_d = issue ? src_addr + ADDR_W'(1) : rd_addr_q;
    req_left_d = issue ? src_left - 16'd1 : req_left_q;
    addr_d = issue ? src_addr : addr_q;
    cs_d = issue;
    inflight_d = cs_q && !abort;
    out_left_d = pop ? out_left_q - 16'd1 : out_left_q;
    done_d = zero_q && !abort;
    zero_d = 1'b0;
    if (accept) begin
      out_left_d = num_words;
      state_d = num_words == 16'd0 ? IDLE : FETCH;
      zero_d = num_words == 16'd0;
    end
    if (state_q == FETCH && req_left_q == 16'd0) state_d = DRAIN;
    if (state_q == DRAIN && pop && out_left_q == 16'd1 && !abort) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_addr_q <= '0;
      req_left_q <= '0;
      out_left_q <= '0;
      addr_q <= '0;
      cs_q <= 1'b0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_addr_q <= rd_addr_d;
      req_left_q <= req_left_d;
      out_left_q <= out_left_d;
      addr_q <= addr_d;
      cs_q <= cs_d;
      inflight_q <= inflight_d;
      done_q <= done_d;
      zero_q <= zero_d;
    end
  end
  led_pix_fifo #(.W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .din(mem_readdata[PIX_W-1:0]),
    .pop(pop),
    .flush(abort),
    .dout(pix_data),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  assign pix_valid = !fifo_empty;
  assign pix_last = pix_valid && out_left_q == 16'd1;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign mem_address = addr_q;
  assign mem_chipselect = cs_q;
endmodule

// File: tb/tb_led_frame_reader.sv
// tb_led_frame_reader: directed scoreboard bench for led_frame_reader
module tb_led_frame_reader;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, pix_ready = 0;
  logic [15:0] base_addr = '0, num_words = '0;
  logic busy, done, mem_chipselect, pix_valid, pix_last;
  logic [15:0] mem_address;
  logic [31:0] mem_readdata = 32'hDEADBEEF;
  logic [23:0] pix_data;
  int tests = 0, fails = 0, cyc = 0, t0 = 0, done_cnt = 0, done_cyc = 0, outst = 0, mode = 0;
  logic busy_at_done = 0;
  logic [23:0] exp_q[$];
  logic [15:0] addr_q[$];

  led_frame_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_readdata(mem_readdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_readdata <= mem_chipselect ? {16'hAB00, mem_address} : 32'hDEADBEEF;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    logic [23:0] e;
    logic [15:0] a;
    @(posedge clk);
    #1;
    cyc++;
    pix_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 99) < 30) : 1'b0;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (mem_chipselect) begin
      outst++;
      check("credit_limit", 32'(outst <= 4), 1);
      if (addr_q.size() > 0) begin
        a = addr_q.pop_front();
        check("mem_address", mem_address, a);
      end else check("spurious_read", mem_chipselect, 0);
    end
    if (pix_valid && pix_ready) begin
      outst--;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_data", pix_data, e);
        check("pix_last", pix_last, 32'(exp_q.size() == 0));
      end else check("spurious_pix", pix_valid, 0);
    end
  endtask

  task automatic launch(logic [15:0] b, logic [15:0] n, int m);
    mode = m;
    for (int i = 0; i < int'(n); i++) begin
      addr_q.push_back(b + 16'(i));
      exp_q.push_back({8'h00, b + 16'(i)});
    end
    base_addr = b;
    num_words = n;
    start = 1;
    done_cnt = 0;
    tick();
    start = 0;
    base_addr = 16'h5555;
    num_words = 16'd7;
    t0 = cyc;
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    check("done_seen", done_cnt, 1);
    check("busy_at_done", busy_at_done, 0);
    check("pixels_left", exp_q.size(), 0);
    repeat (3) tick();
    check("single_done", done_cnt, 1);
  endtask

  task automatic reset_outs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_last", pix_last, 0);
    check("rst_data", pix_data, 0);
  endtask

  initial begin
    repeat (2) tick();
    reset_outs();
    reset_n = 1;
    tick();
    launch(16'h0010, 16'd5, 0);
    check("basic_busy_t1", busy, 1);
    tick();
    check("basic_novalid_t2", pix_valid, 0);
    tick();
    check("basic_valid_t3", pix_valid, 1);
    finish_frame();
    check("basic_done_time", done_cyc, t0 + 7);
    launch(16'h0200, 16'd12, 1);
    finish_frame();
    launch(16'hFFFE, 16'd4, 0);
    finish_frame();
    check("wrap_done_time", done_cyc, t0 + 6);
    launch(16'h0300, 16'd0, 0);
    check("zero_busy", busy, 0);
    finish_frame();
    check("zero_done_time", done_cyc, t0 + 1);
    launch(16'h0400, 16'd20, 2);
    repeat (3) tick();
    abort = 1;
    exp_q.delete();
    addr_q.delete();
    outst = 0;
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_valid", pix_valid, 0);
    check("abort_cs", mem_chipselect, 0);
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_pix", pix_valid, 0);
    launch(16'h0500, 16'd6, 1);
    finish_frame();
    launch(16'h0600, 16'd20, 0);
    repeat (2) tick();
    check("midreset_busy", busy, 1);
    reset_n = 0;
    exp_q.delete();
    addr_q.delete();
    outst = 0;
    tick();
    reset_outs();
    reset_n = 1;
    launch(16'h0700, 16'd3, 0);
    finish_frame();
    check("post_reset_done_time", done_cyc, t0 + 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_frame_reader.md
# led_frame_reader

Avalon-MM read master that fetches a frame of packed LED colour words from the on-chip frame memory and streams them as 24-bit GRB pixels to the downstream LED serial encoder. It sits between the frame memory's second slave port and the encoder. It issues pipelined fixed-latency reads, buffers them in a small FIFO, and applies backpressure through a credit scheme.

## Interface
Parameters:
- ADDR_W, 16, word-address width of the frame memory port
- FIFO_DEPTH, 4, pixel buffer depth; power of two, minimum 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle frame request; ignored while busy
- abort  in  1  cancel the current frame; takes priority over all other inputs except reset
- base_addr  in  ADDR_W  first word address of the frame, sampled on an accepted start
- num_words  in  16  pixel count, sampled on an accepted start
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the frame completes
- mem_address  out  ADDR_W  read address
- mem_chipselect  out  1  read strobe; one word requested per asserted cycle
- mem_readdata  in  32  read data, valid exactly one cycle after mem_chipselect
- pix_data  out  24  GRB pixel, taken from mem_readdata[23:0]; bits [31:24] are discarded
- pix_valid  out  1  pixel available
- pix_ready  in  1  encoder accepts the pixel
- pix_last  out  1  marks the final pixel of the frame

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 latches base_addr into rd_addr and num_words into req_left and out_left.
  - Goes to FETCH, or to IDLE with a done pulse next cycle if num_words=0.
- FETCH:
  - Issues a read (mem_chipselect=1, mem_address=rd_addr) when req_left>0 and fifo_count+inflight < FIFO_DEPTH.
  - On each issue: rd_addr increments (wraps modulo 2^ADDR_W), req_left decrements, and the inflight flag is set for the next cycle.
  - Goes to DRAIN when req_left reaches 0.
- Every returning word (the cycle after an issue) is written into the FIFO unconditionally. The credit check guarantees space.
- Output side:
  - pix_valid = FIFO not empty. A pop occurs on pix_valid & pix_ready, and out_left then decrements.
  - pix_last = pix_valid & (out_left==1).
- DRAIN: on the pop with pix_last=1, goes to IDLE and pulses done the following cycle.
- abort:
  - Next cycle the state is IDLE, the FIFO is flushed, inflight is cleared, and any readdata arriving that cycle is discarded.
  - No done pulse is generated.
  - A start in the same cycle as abort is ignored.
- Values sampled on an accepted start are held for the whole frame. Input changes mid-frame have no effect.
- Simultaneous FIFO push and pop in the same cycle: fifo_count is unchanged, and data order is preserved.
- Reset (reset_n=0 at a clock edge):
  - State IDLE, FIFO empty, counters 0.
  - busy=0, done=0, mem_chipselect=0, mem_address=0, pix_valid=0, pix_last=0, pix_data=0.

## Timing
- start accepted at edge T:
  - busy=1 and the first mem_chipselect in cycle T+1.
  - Data is written into the FIFO at the end of T+2.
  - pix_valid=1 in T+3.
- busy stays high from T+1 through the cycle of the last pixel handshake. done=1 and busy=0 in the following cycle.
- With pix_ready held at 1, sustained throughput is 1 pixel/cycle. An N-pixel frame gives done at T+N+3.
- pix_ready=0: reads stall once fifo_count+inflight reaches FIFO_DEPTH. The FIFO never overflows and no word is dropped.
- All outputs are registered except pix_valid, pix_data and pix_last, which come directly from FIFO registers. There are no combinational paths from pix_ready to mem_chipselect.

## Structure
- Package led_frame_pkg holds:
  - state enum (IDLE/FETCH/DRAIN)
  - PIX_W=24
  - MEM_DATA_W=32
  - read-latency constant RD_LAT=1
- One sub-module, led_pix_fifo:
  - Synchronous FIFO, parameterised width/depth.
  - Register array with push, pop, flush, count, and empty/full outputs.
  - Simultaneous push and pop allowed when full.
- Top level contains the FSM, address/count registers, credit logic and abort handling.

## Test plan
- Basic frame: memory model with word k = 0xAB000000|k, base=0x0010, num_words=5, pix_ready=1.
  - Pixels 0x000010..0x000014 in order, upper byte stripped.
  - pix_last on the 5th pixel.
  - done at T+8, exactly one pulse.
- Backpressure: num_words=12, pix_ready toggling with random 30% duty.
  - Never more than FIFO_DEPTH outstanding (count+inflight ≤ 4).
  - All 12 pixels delivered in order.
  - mem_chipselect stalls while the FIFO is full.
- Address wrap: base=0xFFFE, num_words=4.
  - mem_address sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero length: start with num_words=0.
  - No mem_chipselect, no pix_valid.
  - done=1 in T+2, busy stays 0.
- Abort mid-frame: num_words=20, pix_ready=0, assert abort in cycle T+4.
  - Next cycle: busy=0, pix_valid=0, no done pulse, no reads issued.
  - A fresh start then delivers a correct new frame with no stale pixels.
- Reset mid-frame: reset_n=0 for one cycle during FETCH.
  - All outputs return to their reset values on the next cycle.
  - A start issued when reset_n returns to 1 is accepted normally.
